// File: rtl/contador_bcd_escaneo_pkg.sv
// Shared constants and helpers for the scanned BCD counter.
package contador_bcd_escaneo_pkg;

  localparam int           BCD_WIDTH  = 4;
  localparam logic [3:0]   BCD_MAX    = 4'd9;
  localparam int           MAX_DIGITS = 8;

  // One-hot select for a scan index; callers keep the low DIGITS bits.
  function automatic logic [MAX_DIGITS-1:0] anode_onehot(input logic [3:0] idx);
    logic [MAX_DIGITS-1:0] one;
    one = {{(MAX_DIGITS-1){1'b0}}, 1'b1};
    return one << idx;
  endfunction

endpackage

// File: rtl/contador_bcd_escaneo_digito.sv
// One BCD digit: clear/load/step with ripple carry or borrow to the next digit.
import contador_bcd_escaneo_pkg::*;

module contador_bcd_digito (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clear_i,
  input  logic                 load_i,
  input  logic [BCD_WIDTH-1:0] load_val_i,
  input  logic                 up_i,
  input  logic                 cin_i,
  output logic [BCD_WIDTH-1:0] digit_o,
  output logic [BCD_WIDTH-1:0] digit_d_o,
  output logic                 cout_o
);

  logic [BCD_WIDTH-1:0] digit_q, digit_d;

  // cin_i is only raised by the top when neither clear nor load is active.
  assign cout_o = cin_i & (up_i ? (digit_q == BCD_MAX) : (digit_q == '0));

  always_comb begin
    digit_d = digit_q;
    if (clear_i)
      digit_d = '0;
    else if (load_i)
      digit_d = (load_val_i > BCD_MAX) ? '0 : load_val_i;
    else if (cin_i) begin
      if (up_i)
        digit_d = (digit_q == BCD_MAX) ? '0 : digit_q + 1'b1;
      else
        digit_d = (digit_q == '0) ? BCD_MAX : digit_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) digit_q <= '0;
    else       digit_q <= digit_d;
  end

  assign digit_o   = digit_q;
  assign digit_d_o = digit_d;

endmodule

// File: rtl/contador_bcd_escaneo.sv
// Multi-digit BCD up/down counter with prescaled stepping and a
// time-multiplexed digit scanner feeding a BCD-to-segment converter.
import contador_bcd_escaneo_pkg::*;

module contador_bcd_escaneo #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 50000,
  parameter int SCAN_DIV = 1000
) (
  input  logic                  iClk,
  input  logic                  iReset,
  input  logic                  iEnable,
  input  logic                  iUp,
  input  logic                  iClear,
  input  logic                  iLoad,
  input  logic [4*DIGITS-1:0]   iLoadValue,
  output logic                  oA,
  output logic                  oB,
  output logic                  oC,
  output logic                  oD,
  output logic [DIGITS-1:0]     oAnode,
  output logic [4*DIGITS-1:0]   oCount,
  output logic                  oCarry
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = $clog2(DIGITS);

  logic [PW-1:0] pre_q, pre_d;
  logic [SW-1:0] div_q, div_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [BCD_WIDTH-1:0] seg_q, seg_d;
  logic carry_q;
  logic tick, step, adv;

  logic [DIGITS-1:0][BCD_WIDTH-1:0] count_q, count_d;
  logic [DIGITS:0] cy;

  // Prescaler: clear/load restart it even while counting is disabled.
  assign tick = iEnable && (pre_q == PW'(PRESCALE-1));
  assign step = tick & ~iClear & ~iLoad;

  always_comb begin
    pre_d = pre_q;
    if (iClear || iLoad)
      pre_d = '0;
    else if (iEnable)
      pre_d = tick ? '0 : pre_q + 1'b1;
  end

  assign cy[0] = step;

  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    contador_bcd_digito u_dig (
      .clk_i      (iClk),
      .rst_i      (iReset),
      .clear_i    (iClear),
      .load_i     (iLoad),
      .load_val_i (iLoadValue[BCD_WIDTH*g +: BCD_WIDTH]),
      .up_i       (iUp),
      .cin_i      (cy[g]),
      .digit_o    (count_q[g]),
      .digit_d_o  (count_d[g]),
      .cout_o     (cy[g+1])
    );
  end

  // Scanner runs free of enable/clear/load. On an index change the new
  // digit comes from the count being registered on that same edge.
  assign adv = (div_q == SW'(SCAN_DIV-1));

  always_comb begin
    div_d = adv ? '0 : div_q + 1'b1;
    idx_d = idx_q;
    if (adv)
      idx_d = (idx_q == IW'(DIGITS-1)) ? '0 : idx_q + 1'b1;
    seg_d = adv ? count_d[idx_d] : count_q[idx_q];
  end

  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      pre_q   <= '0;
      div_q   <= '0;
      idx_q   <= '0;
      seg_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      pre_q   <= pre_d;
      div_q   <= div_d;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
      carry_q <= cy[DIGITS];
    end
  end

  logic [MAX_DIGITS-1:0] anode_full;
  assign anode_full = anode_onehot({{(4-IW){1'b0}}, idx_q});
  assign oAnode     = anode_full[DIGITS-1:0];

  assign {oA, oB, oC, oD} = seg_q;
  assign oCount           = count_q;
  assign oCarry           = carry_q;

endmodule

// File: tb/tb_contador_bcd_escaneo.sv
// Self-checking bench: decimal reference model, directed table and random run.
module tb_contador_bcd_escaneo;

  localparam int D = 4;
  localparam int P = 2;
  localparam int S = 3;
  localparam int MAXV = 9999;

  logic iClk = 1'b0, iReset = 1'b1, iEnable = 1'b0, iUp = 1'b1;
  logic iClear = 1'b0, iLoad = 1'b0;
  logic [4*D-1:0] iLoadValue = '0;
  logic oA, oB, oC, oD, oCarry;
  logic [D-1:0] oAnode;
  logic [4*D-1:0] oCount;

  int n_assert = 0, n_fail = 0;
  int m_cnt, m_pre, m_cy, m_div, m_idx, m_seg;

  contador_bcd_escaneo #(.DIGITS(D), .PRESCALE(P), .SCAN_DIV(S)) dut (
    .iClk(iClk), .iReset(iReset), .iEnable(iEnable), .iUp(iUp),
    .iClear(iClear), .iLoad(iLoad), .iLoadValue(iLoadValue),
    .oA(oA), .oB(oB), .oC(oC), .oD(oD),
    .oAnode(oAnode), .oCount(oCount), .oCarry(oCarry)
  );

  always #5 iClk = ~iClk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int digit_of(input int v, input int i);
    int p = 1;
    for (int k = 0; k < i; k++) p = p * 10;
    return (v / p) % 10;
  endfunction

  function automatic logic [4*D-1:0] to_bcd(input int v);
    logic [4*D-1:0] r = '0;
    for (int i = 0; i < D; i++) r[4*i +: 4] = 4'(digit_of(v, i));
    return r;
  endfunction

  function automatic int from_load(input logic [4*D-1:0] lv);
    int v = 0, p = 1, n;
    for (int i = 0; i < D; i++) begin
      n = int'(lv[4*i +: 4]);
      if (n > 9) n = 0;
      v = v + n * p;
      p = p * 10;
    end
    return v;
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_pre = 0; m_cy = 0; m_div = 0; m_idx = 0; m_seg = 0;
  endtask

  task automatic model_edge();
    int old_cnt;
    bit tk;
    old_cnt = m_cnt;
    tk = iEnable && (m_pre == P-1);
    m_cy = 0;
    if (iClear) begin
      m_cnt = 0; m_pre = 0;
    end else if (iLoad) begin
      m_cnt = from_load(iLoadValue); m_pre = 0;
    end else begin
      if (iEnable) m_pre = tk ? 0 : m_pre + 1;
      if (tk) begin
        if (iUp) begin
          if (m_cnt == MAXV) begin m_cnt = 0; m_cy = 1; end
          else m_cnt = m_cnt + 1;
        end else begin
          if (m_cnt == 0) begin m_cnt = MAXV; m_cy = 1; end
          else m_cnt = m_cnt - 1;
        end
      end
    end
    if (m_div == S-1) begin
      m_div = 0;
      m_idx = (m_idx + 1) % D;
      m_seg = digit_of(m_cnt, m_idx);
    end else begin
      m_div = m_div + 1;
      m_seg = digit_of(old_cnt, m_idx);
    end
  endtask

  task automatic check_model();
    chk("count", 32'(oCount), 32'(to_bcd(m_cnt)));
    chk("carry", 32'(oCarry), 32'(m_cy));
    chk("anode", 32'(oAnode), 32'(1 << m_idx));
    chk("seg",   32'({oA, oB, oC, oD}), 32'(m_seg));
  endtask

  task automatic step();
    @(posedge iClk);
    model_edge();
    #1;
    check_model();
  endtask

  typedef struct {
    logic [15:0] load;
    logic        up;
    int          cyc;
    logic [15:0] exp_cnt;
    logic        exp_cy;
  } vec_t;

  vec_t vt[7];

  initial begin
    vt[0] = '{16'h0099, 1'b1, 2, 16'h0100, 1'b0};
    vt[1] = '{16'h9999, 1'b1, 2, 16'h0000, 1'b1};
    vt[2] = '{16'h0000, 1'b0, 2, 16'h9999, 1'b1};
    vt[3] = '{16'h1000, 1'b0, 2, 16'h0999, 1'b0};
    vt[4] = '{16'h3A7F, 1'b1, 0, 16'h3070, 1'b0};
    vt[5] = '{16'h1234, 1'b1, 4, 16'h1236, 1'b0};
    vt[6] = '{16'h0009, 1'b0, 2, 16'h0008, 1'b0};

    // Reset state with no clock edge yet
    model_reset();
    #3;
    chk("rst_count", 32'(oCount), 32'h0);
    chk("rst_anode", 32'(oAnode), 32'h1);
    chk("rst_seg",   32'({oA, oB, oC, oD}), 32'h0);
    chk("rst_carry", 32'(oCarry), 32'h0);
    iReset = 1'b0;

    // Directed table
    foreach (vt[i]) begin
      iLoad = 1'b1; iLoadValue = vt[i].load; iEnable = 1'b0;
      step();
      iLoad = 1'b0; iEnable = (vt[i].cyc > 0); iUp = vt[i].up;
      repeat (vt[i].cyc) step();
      chk($sformatf("vec%0d_count", i), 32'(oCount), 32'(vt[i].exp_cnt));
      chk($sformatf("vec%0d_carry", i), 32'(oCarry), 32'(vt[i].exp_cy));
      iEnable = 1'b0;
      step();
      chk($sformatf("vec%0d_carry_drop", i), 32'(oCarry), 32'h0);
    end

    // Clear beats load beats tick
    iLoad = 1'b1; iLoadValue = 16'h0555; step();
    iLoad = 1'b0; iEnable = 1'b1; iUp = 1'b1; step();
    iClear = 1'b1; iLoad = 1'b1; iLoadValue = 16'h1111; step();
    chk("prio_count", 32'(oCount), 32'h0);
    chk("prio_carry", 32'(oCarry), 32'h0);
    iClear = 1'b0; iLoad = 1'b0; iEnable = 1'b0;

    // Enable low freezes the count
    iLoad = 1'b1; iLoadValue = 16'h0042; step();
    iLoad = 1'b0;
    repeat (10) step();
    chk("hold_count", 32'(oCount), 32'h0042);

    // Scan with 0x4321: sync to the edge where digit 0 gets selected
    iLoad = 1'b1; iLoadValue = 16'h4321; step();
    iLoad = 1'b0;
    begin
      bit found = 0;
      logic [D-1:0] prev;
      prev = oAnode;
      for (int k = 0; k < 20 && !found; k++) begin
        step();
        if (oAnode == 4'b0001 && prev == 4'b1000) found = 1;
        prev = oAnode;
      end
      if (!found) begin
        n_assert++; n_fail++;
        $display("FAIL scan_sync: anode never wrapped to 0001 (now %b)", oAnode);
      end
      for (int k = 0; k < 15; k++) begin
        int e;
        e = (k / 3) % 4;
        chk($sformatf("scan_anode%0d", k), 32'(oAnode), 32'(1 << e));
        chk($sformatf("scan_seg%0d", k), 32'({oA, oB, oC, oD}), 32'(e + 1));
        step();
      end
    end

    // Async reset mid-count
    iEnable = 1'b1; iUp = 1'b1;
    repeat (5) step();
    #2 iReset = 1'b1;
    #1;
    model_reset();
    chk("arst_count", 32'(oCount), 32'h0);
    chk("arst_anode", 32'(oAnode), 32'h1);
    chk("arst_seg",   32'({oA, oB, oC, oD}), 32'h0);
    chk("arst_carry", 32'(oCarry), 32'h0);
    iReset = 1'b0;

    // Random run against the model
    for (int k = 0; k < 400; k++) begin
      iClear     = ($urandom_range(19) == 0);
      iLoad      = ($urandom_range(14) == 0);
      iLoadValue = 16'($urandom);
      if ($urandom_range(1) == 0)
        iLoadValue = (($urandom_range(1) == 0) ? 16'h9999 : 16'h0000);
      iEnable    = ($urandom_range(3) != 0);
      iUp        = 1'($urandom);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
